// File: rtl/dcache_controller.sv
// MEM-stage data cache: direct-mapped, write-back, write-allocate, 16 x 256-bit lines.
// Load hits return data combinationally; misses stall the pipeline while a line is evicted and refilled.
module dcache_controller #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 32 - INDEX_W - 5,
  parameter int LINE_W  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        dbg_state_o
);

  localparam int NLINES = 1 << INDEX_W;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;

  logic [1:0]        r_state;
  logic [NLINES-1:0] r_valid;
  logic [NLINES-1:0] r_dirty;
  logic [TAG_W-1:0]  r_tag  [0:NLINES-1];
  logic [LINE_W-1:0] r_data [0:NLINES-1];

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [2:0]         w_word;
  logic [7:0]         w_bit_lo;
  logic               w_req;
  logic               w_is_write;
  logic               w_hit;
  logic               w_read_hit;
  logic               w_write_hit;
  logic               w_miss;
  logic [LINE_W-1:0]  w_line;
  logic [31:0]        w_word_data;
  logic               w_unused_addr;

  assign w_index       = cpu_addr_i[INDEX_W+4:5];
  assign w_tag         = cpu_addr_i[31:INDEX_W+5];
  assign w_word        = cpu_addr_i[4:2];
  assign w_bit_lo      = {w_word, 5'b0};
  assign w_unused_addr = &{1'b0, cpu_addr_i[1:0]};

  // A simultaneous read and write request is handled as a store.
  assign w_req       = cpu_MemRead_i | cpu_MemWrite_i;
  assign w_is_write  = cpu_MemWrite_i;
  assign w_hit       = w_req & r_valid[w_index] & (r_tag[w_index] == w_tag);
  assign w_read_hit  = w_hit & ~w_is_write;
  assign w_write_hit = w_hit & w_is_write;
  assign w_miss      = w_req & ~w_hit;

  assign w_line      = r_data[w_index];
  assign w_word_data = w_line[w_bit_lo +: 32];

  assign dbg_state_o = r_state;

  // Everything is forced quiet while reset is held so an in-flight transfer is dropped at once.
  always_comb begin
    cpu_stall_o  = 1'b0;
    cpu_data_o   = 32'd0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'd0;
    mem_data_o   = '0;
    if (!rst_i) begin
      case (r_state)
        IDLE: begin
          cpu_stall_o = w_miss;
          if (w_read_hit) cpu_data_o = w_word_data;
        end
        WRITEBACK: begin
          cpu_stall_o  = 1'b1;
          mem_enable_o = 1'b1;
          mem_write_o  = 1'b1;
          mem_addr_o   = {r_tag[w_index], w_index, 5'b0};
          mem_data_o   = w_line;
        end
        ALLOCATE: begin
          cpu_stall_o  = 1'b1;
          mem_enable_o = 1'b1;
          mem_addr_o   = {w_tag, w_index, 5'b0};
        end
        default: cpu_stall_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_write_hit) begin
            r_dirty[w_index] <= 1'b1;
          end else if (w_miss) begin
            r_state <= (r_valid[w_index] & r_dirty[w_index]) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: if (mem_ack_i) r_state <= ALLOCATE;
        ALLOCATE: begin
          if (mem_ack_i) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
            r_state          <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays need no reset; the valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (r_state == IDLE && w_write_hit) begin
        r_data[w_index][w_bit_lo +: 32] <= cpu_data_i;
      end else if (r_state == ALLOCATE && mem_ack_i) begin
        r_data[w_index] <= mem_data_i;
        r_tag[w_index]  <= w_tag;
      end
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: the bench plays the backing memory by hand,
// driving ack and refill lines at fixed cycles and checking every output against hand-computed values.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [1:0]   dbg_state_o;

  int checks = 0;
  int errors = 0;

  logic [255:0] line1, line2, line3, line4;

  dcache_controller dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i),
    .dbg_state_o    (dbg_state_o)
  );

  // Clock and reset
  always #5 clk_i = ~clk_i;

  // Scoreboard compare: every comparison goes through here
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cpu_req(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    cpu_MemRead_i  = rd;
    cpu_MemWrite_i = wr;
    cpu_addr_i     = addr;
    cpu_data_i     = data;
    #1;
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  initial begin
    line1 = make_line(32'h1000_0000);
    line1[31:0] = 32'hDEAD_BEEF;
    line2 = make_line(32'h2000_0000);
    line3 = make_line(32'h3000_0000);
    line4 = make_line(32'h4000_0000);

    rst_i = 1'b1;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    cpu_req(1'b1, 1'b0, 32'h0000_0040, 32'd0);
    step();
    check("rst_stall", cpu_stall_o, 0);
    check("rst_enable", mem_enable_o, 0);
    check("rst_data", cpu_data_o, 0);
    check("rst_addr", mem_addr_o, 0);
    step();
    rst_i = 1'b0;
    #1;

    // Scenario 1: cold load miss at 0x40, ack in the third allocate cycle
    check("s1_c1_stall", cpu_stall_o, 1);
    check("s1_c1_enable", mem_enable_o, 0);
    step();
    check("s1_c2_stall", cpu_stall_o, 1);
    check("s1_c2_enable", mem_enable_o, 1);
    check("s1_c2_addr", mem_addr_o, 32'h40);
    check("s1_c2_write", mem_write_o, 0);
    check("s1_c2_state", dbg_state_o, 2);
    step();
    check("s1_c3_stall", cpu_stall_o, 1);
    step();
    mem_ack_i = 1'b1;
    mem_data_i = line1;
    #1;
    check("s1_c4_stall", cpu_stall_o, 1);
    step();
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    #1;
    check("s1_hit_stall", cpu_stall_o, 0);
    check("s1_hit_data", cpu_data_o, 32'hDEAD_BEEF);

    // Scenario 2: neighbouring word hits
    step();
    cpu_req(1'b1, 1'b0, 32'h0000_0044, 32'd0);
    check("s2_stall", cpu_stall_o, 0);
    check("s2_data", cpu_data_o, 32'h1000_0001);
    check("s2_enable", mem_enable_o, 0);

    // Scenario 3: store hit to word 7, then conflicting load forces write-back
    step();
    cpu_req(1'b0, 1'b1, 32'h0000_005C, 32'h1234_5678);
    check("s3_st_stall", cpu_stall_o, 0);
    check("s3_st_rdata", cpu_data_o, 0);
    step();
    check("s3_dirty2", dut.r_dirty[2], 1);
    cpu_req(1'b1, 1'b0, 32'h0000_025C, 32'd0);
    check("s3_miss_stall", cpu_stall_o, 1);
    step();
    check("s3_wb_enable", mem_enable_o, 1);
    check("s3_wb_write", mem_write_o, 1);
    check("s3_wb_addr", mem_addr_o, 32'h40);
    check("s3_wb_word7", mem_data_o[255:224], 32'h1234_5678);
    check("s3_wb_word0", mem_data_o[31:0], 32'hDEAD_BEEF);
    mem_ack_i = 1'b1;
    step();
    mem_data_i = line2;
    #1;
    check("s3_al_enable", mem_enable_o, 1);
    check("s3_al_write", mem_write_o, 0);
    check("s3_al_addr", mem_addr_o, 32'h240);
    step();
    mem_ack_i = 1'b0;
    #1;
    check("s3_hit_stall", cpu_stall_o, 0);
    check("s3_hit_data", cpu_data_o, 32'h2000_0007);

    // Scenario 4: store miss to clean index 5 skips write-back
    step();
    cpu_req(1'b0, 1'b1, 32'h0000_00A0, 32'hCAFE_F00D);
    check("s4_miss_stall", cpu_stall_o, 1);
    step();
    check("s4_al_write", mem_write_o, 0);
    check("s4_al_addr", mem_addr_o, 32'hA0);
    mem_ack_i = 1'b1;
    mem_data_i = line3;
    step();
    mem_ack_i = 1'b0;
    #1;
    check("s4_merge_stall", cpu_stall_o, 0);
    check("s4_clean_after_fill", dut.r_dirty[5], 0);
    step();
    check("s4_dirty5", dut.r_dirty[5], 1);
    cpu_req(1'b1, 1'b0, 32'h0000_00A0, 32'd0);
    check("s4_word0", cpu_data_o, 32'hCAFE_F00D);
    cpu_req(1'b1, 1'b0, 32'h0000_00BC, 32'd0);
    check("s4_word7", cpu_data_o, 32'h3000_0007);

    // Index 15 is independent of index 0 and 5
    step();
    cpu_req(1'b1, 1'b0, 32'h0000_01FC, 32'd0);
    check("idx15_miss", cpu_stall_o, 1);
    step();
    check("idx15_addr", mem_addr_o, 32'h1E0);
    mem_ack_i = 1'b1;
    mem_data_i = line4;
    step();
    mem_ack_i = 1'b0;
    #1;
    check("idx15_data", cpu_data_o, 32'h4000_0007);
    cpu_req(1'b1, 1'b0, 32'h0000_00A4, 32'd0);
    check("idx5_kept", cpu_data_o, 32'h3000_0001);

    // Scenario 5: reset aborts an allocate, late ack ignored
    step();
    cpu_req(1'b1, 1'b0, 32'h0000_0300, 32'd0);
    check("s5_miss_stall", cpu_stall_o, 1);
    step();
    check("s5_al_enable", mem_enable_o, 1);
    rst_i = 1'b1;
    cpu_req(1'b0, 1'b0, 32'h0000_0300, 32'd0);
    check("s5_rst_enable", mem_enable_o, 0);
    check("s5_rst_stall", cpu_stall_o, 0);
    step();
    rst_i = 1'b0;
    mem_ack_i = 1'b1;
    mem_data_i = line2;
    #1;
    check("s5_late_ack_enable", mem_enable_o, 0);
    step();
    mem_ack_i = 1'b0;
    #1;
    check("s5_valid8", dut.r_valid[8], 0);
    cpu_req(1'b1, 1'b0, 32'h0000_0300, 32'd0);
    check("s5_remiss", cpu_stall_o, 1);
    step();
    check("s5_realloc_addr", mem_addr_o, 32'h300);
    mem_ack_i = 1'b1;
    mem_data_i = line3;
    step();
    mem_ack_i = 1'b0;
    #1;
    check("s5_hit_data", cpu_data_o, 32'h3000_0000);

    // Scenario 6: idle cycles with stray acks and noise on the refill bus
    cpu_req(1'b0, 1'b0, 32'h0000_0300, 32'd0);
    for (int i = 0; i < 10; i++) begin
      mem_ack_i = 1'($urandom_range(0, 1));
      for (int j = 0; j < 8; j++) mem_data_i[j*32 +: 32] = $urandom;
      #1;
      check("s6_stall", cpu_stall_o, 0);
      check("s6_enable", mem_enable_o, 0);
      check("s6_addr", mem_addr_o, 0);
      step();
    end
    mem_ack_i = 1'b0;
    cpu_req(1'b1, 1'b0, 32'h0000_0304, 32'd0);
    check("s6_array_kept", cpu_data_o, 32'h3000_0001);
    check("s6_hit_stall", cpu_stall_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- MEM-stage data cache controller: direct-mapped, write-back, write-allocate.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Returns load data (MEMdata) to MEM/WB and produces the memory-stall signal. That signal drives MemStall of MEM/WB and freezes all upstream pipeline registers.
- Talks to a 256-bit-line backing data memory over an enable/ack handshake.

Parameters:
- INDEX_W, 4, index bits; number of lines = 2^INDEX_W = 16.
- TAG_W, 23, tag bits; equals 32 - INDEX_W - 5.
- LINE_W, 256, line width in bits (32 bytes, 8 words).

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous reset, active-high.
- cpu_addr_i  in  32  byte address from EX/MEM (ALU result).
- cpu_data_i  in  32  store data.
- cpu_MemRead_i  in  1  load request.
- cpu_MemWrite_i  in  1  store request.
- cpu_data_o  out  32  load data to MEM/WB MEMdata.
- cpu_stall_o  out  1  memory stall; high while the request is not yet satisfied.
- mem_addr_o  out  32  line-aligned address to backing memory.
- mem_data_o  out  LINE_W  write-back line data.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = write line, 0 = read line.
- mem_data_i  in  LINE_W  refill line data; valid when mem_ack_i = 1.
- mem_ack_i  in  1  one-cycle completion pulse from memory.

Behaviour:
- Address split: offset = addr[4:0], word select = addr[4:2], index = addr[INDEX_W+4:5], tag = addr[31:INDEX_W+5].
- Per-line storage: valid bit, dirty bit, tag, LINE_W data. All internal registers.
- Request = cpu_MemRead_i | cpu_MemWrite_i. If both are high, treat as a write.
- Hit = request & valid[index] & (tag[index] == addr tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE.

IDLE:
- cpu_stall_o = request & ~hit, combinational, so it is asserted in the same cycle as the miss.
- Read hit: cpu_data_o = selected word, combinational. Zero added latency; stall stays 0.
- Write hit: at posedge, the selected word is replaced with cpu_data_i and dirty is set. No stall.
- No request: stall 0, no array update.
- cpu_data_o is 0 when the request is not a read hit.
- Miss transition at posedge: to WRITEBACK if the victim is valid and dirty, otherwise to ALLOCATE.

WRITEBACK:
- mem_enable_o = 1, mem_write_o = 1.
- mem_addr_o = {victim tag, index, 5'b0}; mem_data_o = victim line.
- Held constant until mem_ack_i; then go to ALLOCATE.

ALLOCATE:
- mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {cpu tag, index, 5'b0}.
- On mem_ack_i: line data = mem_data_i, tag = cpu tag, valid = 1, dirty = 0; go to IDLE.
- The request is re-evaluated in IDLE the next cycle as a hit. Stall drops combinationally and a pending store merges and sets dirty then.

General rules:
- cpu_stall_o = 1 throughout WRITEBACK and ALLOCATE.
- In IDLE, mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0 and mem_data_o = 0.
- mem_ack_i is ignored in IDLE.
- An ack arriving in the first cycle of enable is legal.
- The CPU-side inputs are stable while stall is high, because upstream registers are frozen. The controller samples them live and does not latch them.

Reset:
- Every valid and dirty bit cleared; state forced to IDLE.
- Outputs while rst_i is high: cpu_stall_o = 0, mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0, cpu_data_o = 0.
- Reset during WRITEBACK or ALLOCATE aborts the transfer: enable is low from the reset cycle onward and no partial line is written.
- A late ack after reset is ignored.

Boundaries:
- Index 0 and index 15 lines are independent.
- Word select 7 (offset 0x1C) maps to line bits [255:224]; word 0 maps to [31:0].
- A clean victim skips WRITEBACK.
- Back-to-back misses to the same index with different tags evict each time.

Test Plan:
1. Reset, then load from 0x0000_0040 with memory returning a line whose word 0 = 0xDEAD_BEEF and ack after 3 cycles. Required: stall high 4 cycles; mem_addr_o = 0x40, mem_write_o = 0; then cpu_data_o = 0xDEAD_BEEF with stall low.
2. Load from 0x0000_0044 right after scenario 1. Required: hit, stall 0 in that cycle, cpu_data_o = word 1 of the refilled line, mem_enable_o = 0.
3. Store 0x1234_5678 to 0x0000_005C (hit). Required: no stall, dirty[2] = 1. Then load 0x0000_025C (same index 2, tag 1). Required: WRITEBACK to 0x40 with line bits [255:224] = 0x1234_5678, then ALLOCATE from 0x240.
4. Store miss to clean index 5 at 0x0000_00A0. Required: no WRITEBACK, ALLOCATE from 0xA0; after ack, word 0 = store data and dirty[5] = 1.
5. Assert rst_i during ALLOCATE. Required: mem_enable_o = 0 and stall = 0 in the reset cycle; a later ack does not set valid; the next load to the same address misses again.
6. No request for 10 cycles with random mem_ack_i pulses. Required: stall stays 0, enable stays 0, no array change.
